// File: rtl/jtag_to_onchipmem_transfer_done_if.sv
// ---------------------------------------------------------------------------
// jtag_to_onchipmem_transfer_done_if
//
// Avalon-MM slave bus bundle for the transfer-done output PIO.
//
// Signals:
//   address     3   register select (word index)
//   chipselect  1   slave select
//   write_n     1   active-low write strobe
//   writedata   32  write data
//   readdata    32  registered read data (driven by the slave)
//
// Modports:
//   master  drives address/chipselect/write_n/writedata, samples readdata
//   slave   samples the request signals, drives readdata
// ---------------------------------------------------------------------------
interface jtag_to_onchipmem_transfer_done_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/jtag_to_onchipmem_transfer_done.sv
// ---------------------------------------------------------------------------
// jtag_to_onchipmem_transfer_done
//
// Avalon-MM output PIO written by the JTAG master. It drives level outputs
// (out_port) and fixed-length strobes (pulse_port) into the fabric, e.g. a
// "transfer done" flag for the on-chip memory logic. Reads are registered
// with one cycle of latency, matching the start-transfer input PIO.
//
// Parameters:
//   DATA_WIDTH    width of out_port, pulse_port and the data path (1..32)
//   RESET_VALUE   out_port value after reset
//   PULSE_CYCLES  cycles each pulse_port bit stays high per launch (>=1)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   bus         Avalon-MM slave (address, chipselect, write_n, writedata,
//               readdata)
//   out_port    level outputs
//   pulse_port  timed strobe outputs
//   busy        high while any pulse_port bit is high
//   irq         pulse-completion interrupt (IRQ build only)
//
// Register map (word address):
//   0 DATA     RW  out_port
//   1 PULSE    W launches/retriggers pulses, R current pulse mask
//   2 IRQMASK  RW bit 0 (IRQ build), else reads 0
//   3 EDGECAP  R, any write clears bit 0 (IRQ build), else reads 0
//   4 OUTSET   W out_port |= data, reads 0
//   5 OUTCLR   W out_port &= ~data, reads 0
//   6,7        reserved, read 0
//
// Build option:
//   `define JTAG_TO_ONCHIPMEM_TRANSFER_DONE_IRQ_EN adds the irq port and the
//   IRQMASK/EDGECAP bits. Without it no interrupt flops exist.
// ---------------------------------------------------------------------------
module jtag_to_onchipmem_transfer_done #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
    parameter int unsigned           PULSE_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    jtag_to_onchipmem_transfer_done_if.slave bus,
    output logic [DATA_WIDTH-1:0]            out_port,
    output logic [DATA_WIDTH-1:0]            pulse_port,
    output logic                             busy
`ifdef JTAG_TO_ONCHIPMEM_TRANSFER_DONE_IRQ_EN
    ,
    output logic                             irq
`endif
);

    localparam int unsigned         CNT_W      = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        ADDR_DATA    = 3'd0,
        ADDR_PULSE   = 3'd1,
        ADDR_IRQMASK = 3'd2,
        ADDR_EDGECAP = 3'd3,
        ADDR_OUTSET  = 3'd4,
        ADDR_OUTCLR  = 3'd5
    } reg_addr_e;

    // The pulse mask doubles as the state register: an empty mask is IDLE.
    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_e;

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic                  wr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  launch;

    assign wr     = bus.chipselect & ~bus.write_n;
    assign wdata  = bus.writedata[DATA_WIDTH-1:0];
    // A zero write to PULSE neither launches nor retriggers.
    assign launch = wr && (bus.address == ADDR_PULSE) && (wdata != '0);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] out_q,  out_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]      cnt_q,  cnt_d;
    logic [31:0]           rd_mux;
    logic [31:0]           readdata_q;
    pulse_state_e          pulse_state;

    assign pulse_state = (mask_q == '0) ? PULSE_IDLE : PULSE_ACTIVE;

    // -----------------------------------------------------------------------
    // Level output register: DATA load, OUTSET, OUTCLR
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        out_d = out_q;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:   out_d = wdata;
                ADDR_OUTSET: out_d = out_q | wdata;
                ADDR_OUTCLR: out_d = out_q & ~wdata;
                default:     out_d = out_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Pulse engine next state
    // -----------------------------------------------------------------------
    always_comb begin
        mask_d = mask_q;
        cnt_d  = cnt_q;
        case (pulse_state)
            PULSE_IDLE: begin
                if (launch) begin
                    mask_d = wdata;
                    cnt_d  = CNT_RELOAD;
                end
            end
            PULSE_ACTIVE: begin
                // A retrigger takes priority over expiry, so a write landing
                // on the last cycle stretches the pulse without a low gap.
                if (launch) begin
                    mask_d = mask_q | wdata;
                    cnt_d  = CNT_RELOAD;
                end else if (cnt_q == '0) begin
                    mask_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                mask_d = '0;
                cnt_d  = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Optional interrupt logic
    // -----------------------------------------------------------------------
`ifdef JTAG_TO_ONCHIPMEM_TRANSFER_DONE_IRQ_EN
    logic irqmask_q;
    logic edgecap_q, edgecap_d;
    logic was_active_q;
    logic pulse_fell;

    // was_active_q delays the ACTIVE->IDLE detection by one cycle, so EDGECAP
    // sets on the cycle after the mask clears. Reset clears it too, so an
    // aborted pulse never produces an event.
    assign pulse_fell = was_active_q && (pulse_state == PULSE_IDLE);

    always_comb begin
        edgecap_d = edgecap_q;
        if (pulse_fell) begin
            edgecap_d = 1'b1;
        end else if (wr && (bus.address == ADDR_EDGECAP)) begin
            edgecap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q    <= 1'b0;
            edgecap_q    <= 1'b0;
            was_active_q <= 1'b0;
        end else begin
            if (wr && (bus.address == ADDR_IRQMASK)) begin
                irqmask_q <= bus.writedata[0];
            end
            edgecap_q    <= edgecap_d;
            was_active_q <= (pulse_state == PULSE_ACTIVE);
        end
    end

    assign irq = edgecap_q & irqmask_q;
`endif

    // -----------------------------------------------------------------------
    // Read mux: sampled every clock from pre-write register values
    // -----------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux[DATA_WIDTH-1:0] = out_q;
            ADDR_PULSE:   rd_mux[DATA_WIDTH-1:0] = mask_q;
`ifdef JTAG_TO_ONCHIPMEM_TRANSFER_DONE_IRQ_EN
            ADDR_IRQMASK: rd_mux[0] = irqmask_q;
            ADDR_EDGECAP: rd_mux[0] = edgecap_q;
`endif
            default:      rd_mux = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Main registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q      <= RESET_VALUE;
            mask_q     <= '0;
            cnt_q      <= '0;
            readdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // pre-edge values, which is what gives reads their pre-write data.
            out_q      <= out_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            readdata_q <= rd_mux;
        end
    end

    assign out_port     = out_q;
    assign pulse_port   = mask_q;
    assign busy         = |mask_q;
    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_jtag_to_onchipmem_transfer_done.sv
// ---------------------------------------------------------------------------
// tb_jtag_to_onchipmem_transfer_done
//
// Self-checking bench for the transfer-done output PIO. Directed sequences
// cover reset, DATA/OUTSET/OUTCLR, pulse length, retrigger, expiry-cycle
// retrigger, interrupt and mid-pulse reset; a randomized phase follows.
// Expected values come from a cycle-indexed behavioural model: a pulse is a
// mask plus an absolute end-edge number.
// ---------------------------------------------------------------------------
module tb_jtag_to_onchipmem_transfer_done;

    localparam int          DW  = 32;
    localparam int          PC  = 4;
    localparam logic [31:0] RV  = 32'h0000_0005;
`ifdef JTAG_TO_ONCHIPMEM_TRANSFER_DONE_IRQ_EN
    localparam bit          IRQ_BUILD = 1'b1;
`else
    localparam bit          IRQ_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] out_port;
    logic [DW-1:0] pulse_port;
    logic          busy;
`ifdef JTAG_TO_ONCHIPMEM_TRANSFER_DONE_IRQ_EN
    logic          irq;
`endif

    jtag_to_onchipmem_transfer_done_if bus ();

    jtag_to_onchipmem_transfer_done #(
        .DATA_WIDTH   (DW),
        .RESET_VALUE  (RV),
        .PULSE_CYCLES (PC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .out_port   (out_port),
        .pulse_port (pulse_port),
        .busy       (busy)
`ifdef JTAG_TO_ONCHIPMEM_TRANSFER_DONE_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] m_out, m_mask, m_pulse, m_rd;
    bit          m_irqmask, m_edgecap, m_fell;
    int          m_edge, m_end;

    task automatic model_reset();
        m_out     = RV;
        m_mask    = '0;
        m_pulse   = '0;
        m_rd      = '0;
        m_irqmask = 1'b0;
        m_edgecap = 1'b0;
        m_fell    = 1'b0;
        m_edge    = 0;
        m_end     = 0;
    endtask

    task automatic model_edge(input logic [2:0] a, input bit cs, input bit wn, input logic [31:0] wd);
        bit          wr;
        logic [31:0] old_pulse;
        wr        = cs & ~wn;
        old_pulse = m_pulse;
        m_edge++;
        case (a)
            3'd0:    m_rd = m_out;
            3'd1:    m_rd = m_pulse;
            3'd2:    m_rd = IRQ_BUILD ? {31'b0, m_irqmask} : 32'h0;
            3'd3:    m_rd = IRQ_BUILD ? {31'b0, m_edgecap} : 32'h0;
            default: m_rd = 32'h0;
        endcase
        if (wr) begin
            case (a)
                3'd0: m_out = wd;
                3'd4: m_out = m_out | wd;
                3'd5: m_out = m_out & ~wd;
                3'd2: if (IRQ_BUILD) m_irqmask = wd[0];
                3'd1: if (wd != 0) begin
                    m_mask = (m_pulse != 0) ? (m_mask | wd) : wd;
                    m_end  = m_edge + PC;
                end
                default: ;
            endcase
        end
        if (IRQ_BUILD) begin
            if (m_fell)                 m_edgecap = 1'b1;
            else if (wr && a == 3'd3)   m_edgecap = 1'b0;
        end
        m_pulse = (m_edge < m_end) ? m_mask : 32'h0;
        if (m_pulse == 0) m_mask = '0;
        m_fell = (old_pulse != 0) && (m_pulse == 0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus: drive at negedge, model at posedge, compare at next negedge
    // ------------------------------------------------------------------
    task automatic step(input logic [2:0] a, input bit cs, input bit wn, input logic [31:0] wd);
        bus.address    = a;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
        @(posedge clk);
        model_edge(a, cs, wn, wd);
        @(negedge clk);
        check("out_port",   out_port,     m_out);
        check("pulse_port", pulse_port,   m_pulse);
        check("busy",       {31'b0, busy}, {31'b0, (m_pulse != 0)});
        check("readdata",   bus.readdata, m_rd);
`ifdef JTAG_TO_ONCHIPMEM_TRANSFER_DONE_IRQ_EN
        check("irq",        {31'b0, irq}, {31'b0, (m_edgecap & m_irqmask)});
`endif
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        step(a, 1'b1, 1'b0, d);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        step(a, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'd0, 1'b0, 1'b1, 32'h0);
    endtask

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        reset_n        = 1'b0;
        model_reset();

        // 1: reset state
        #12;
        check("rst_out_port",   out_port,            32'h5);
        check("rst_pulse_port", pulse_port,          32'h0);
        check("rst_readdata",   bus.readdata,        32'h0);
        check("rst_busy",       {31'b0, busy},       32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        // 2: DATA write then read
        wr_reg(3'd0, 32'hA5A5_0F0F);
        check("data_out", out_port, 32'hA5A5_0F0F);
        rd_reg(3'd0);
        check("data_rd", bus.readdata, 32'hA5A5_0F0F);

        // same-cycle write and read return the pre-write value
        wr_reg(3'd0, 32'h1234_5678);
        check("rw_same_cycle", bus.readdata, 32'hA5A5_0F0F);

        // 3: OUTSET / OUTCLR
        wr_reg(3'd0, 32'h0000_00FF);
        wr_reg(3'd4, 32'h0000_0F00);
        check("outset", out_port, 32'h0000_0FFF);
        wr_reg(3'd5, 32'h0000_000F);
        check("outclr", out_port, 32'h0000_0FF0);
        rd_reg(3'd4);
        check("outset_rd0", bus.readdata, 32'h0);

        // 4a: single pulse lasts exactly PC cycles
        wr_reg(3'd1, 32'h3);
        for (int i = 1; i < PC; i++) begin
            idle(1);
            check("pulse_hold", pulse_port, 32'h3);
        end
        idle(1);
        check("pulse_end", pulse_port, 32'h0);
        idle(2);

        // 4b: retrigger two cycles in extends and merges
        wr_reg(3'd1, 32'h3);
        idle(1);
        wr_reg(3'd1, 32'h4);
        check("retrig_mask", pulse_port, 32'h7);
        for (int i = 1; i < PC; i++) begin
            idle(1);
            check("retrig_hold", pulse_port, 32'h7);
        end
        idle(1);
        check("retrig_end", pulse_port, 32'h0);

        // zero write to PULSE does nothing
        wr_reg(3'd1, 32'h0);
        check("pulse_zero", pulse_port, 32'h0);
        idle(3);

        // retrigger on the expiry cycle: no low gap
        wr_reg(3'd1, 32'h1);
        idle(PC - 1);
        wr_reg(3'd1, 32'h2);
        check("expiry_retrig", pulse_port, 32'h3);
        idle(PC + 3);

        // 5: interrupt (model expects 0 on addr 2/3 in the plain build)
        wr_reg(3'd2, 32'h1);
        wr_reg(3'd1, 32'h1);
        idle(PC);
        check("irq_not_yet", pulse_port, 32'h0);
        idle(1);
`ifdef JTAG_TO_ONCHIPMEM_TRANSFER_DONE_IRQ_EN
        check("irq_rise", {31'b0, irq}, 32'h1);
`endif
        rd_reg(3'd3);
        wr_reg(3'd3, 32'h0);
`ifdef JTAG_TO_ONCHIPMEM_TRANSFER_DONE_IRQ_EN
        check("irq_clear", {31'b0, irq}, 32'h0);
`endif
        // set wins over a same-cycle clear
        wr_reg(3'd1, 32'h1);
        idle(PC);
        wr_reg(3'd3, 32'h0);
        rd_reg(3'd3);
        wr_reg(3'd3, 32'hFFFF_FFFF);
        rd_reg(3'd2);

        // 6: reset mid-pulse aborts immediately, no event
        wr_reg(3'd1, 32'h2);
        idle(1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_pulse", pulse_port,      32'h0);
        check("async_rst_busy",  {31'b0, busy},   32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle(PC + 2);
        rd_reg(3'd3);
        check("rst_no_edgecap", bus.readdata, 32'h0);

        // Randomized phase
        wr_reg(3'd2, 32'h1);
        for (int i = 0; i < 600; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            bit          cs;
            bit          wn;
            a  = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 1) == 1);
            d  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            step(a, cs, wn, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
